// File: rtl/fpnew_pkg_snax.sv
// Shared floating-point format descriptions used by the SNAX FP datapath.
// Provides the format enum and width helpers.
package fpnew_pkg_snax;

    typedef enum logic [2:0] {
        FP32    = 3'd0,
        FP64    = 3'd1,
        FP16    = 3'd2,
        FP8     = 3'd3,
        FP16ALT = 3'd4
    } fp_format_e;

    function automatic int unsigned exp_bits(fp_format_e fmt);
        case (fmt)
            FP32:    return 8;
            FP64:    return 11;
            FP16:    return 5;
            FP8:     return 5;
            FP16ALT: return 8;
            default: return 8;
        endcase
    endfunction

    function automatic int unsigned man_bits(fp_format_e fmt);
        case (fmt)
            FP32:    return 23;
            FP64:    return 52;
            FP16:    return 10;
            FP8:     return 2;
            FP16ALT: return 7;
            default: return 23;
        endcase
    endfunction

    function automatic int unsigned fp_width(fp_format_e fmt);
        return 1 + exp_bits(fmt) + man_bits(fmt);
    endfunction

endpackage

// File: rtl/fp_add.sv
// Combinational mixed-format FP adder, round-to-nearest-even.
// Operands are widened into the output format (which must be at least as wide
// in exponent and mantissa). NaNs collapse to the canonical quiet NaN and an
// exact-zero sum is always +0.
module fp_add
    import fpnew_pkg_snax::*;
#(
    parameter fp_format_e FpFormat_a   = FP16,
    parameter fp_format_e FpFormat_b   = FP32,
    parameter fp_format_e FpFormat_out = FP32,
    localparam int unsigned WidthA   = fp_width(FpFormat_a),
    localparam int unsigned WidthB   = fp_width(FpFormat_b),
    localparam int unsigned WidthOut = fp_width(FpFormat_out)
) (
    input  logic [WidthA-1:0]   operand_a_i,
    input  logic [WidthB-1:0]   operand_b_i,
    output logic [WidthOut-1:0] result_o
);

    localparam int EA     = int'(exp_bits(FpFormat_a));
    localparam int MA     = int'(man_bits(FpFormat_a));
    localparam int EB     = int'(exp_bits(FpFormat_b));
    localparam int MB     = int'(man_bits(FpFormat_b));
    localparam int EO     = int'(exp_bits(FpFormat_out));
    localparam int MO     = int'(man_bits(FpFormat_out));
    localparam int BiasO  = (1 << (EO - 1)) - 1;
    localparam int MaxExp = (1 << EO) - 1;
    // hidden bit + fraction + guard/round/sticky
    localparam int W      = MO + 4;

    // Operand rebased to the output bias with a normalised significand.
    typedef struct packed {
        logic               sgn;
        logic               nan;
        logic               inf;
        logic signed [31:0] ex;
        logic [MO:0]        sig;
    } unp_t;

    function automatic unp_t unpack(logic [63:0] v, int eb, int mb);
        unp_t        u;
        logic [63:0] m, full;
        int          e, bias, lead;
        bias = (1 << (eb - 1)) - 1;
        e    = int'((v >> mb) & ((64'd1 << eb) - 64'd1));
        m    = v & ((64'd1 << mb) - 64'd1);
        lead = 0;
        for (int i = 0; i < 64; i++)
            if (i < mb && m[i]) lead = i;
        full = (e != 0) ? (m | (64'd1 << mb)) : m;
        if (e != 0) lead = mb;
        u.sgn = v[eb + mb];
        u.nan = (e == (1 << eb) - 1) && (m != 64'd0);
        u.inf = (e == (1 << eb) - 1) && (m == 64'd0);
        // zero gets an exponent far below anything real so it always aligns away
        if (full == 64'd0)  u.ex = -(1 << (EO + 1));
        else if (e != 0)    u.ex = e - bias + BiasO;
        else                u.ex = 1 - bias - (mb - lead) + BiasO;
        full  = full << (MO - lead);
        u.sig = full[MO:0];
        return u;
    endfunction

    unp_t             ua, ub, big, sml;
    logic [W-1:0]     big_x, sml_x, nrm;
    logic [W:0]       raw;
    logic [EO+MO-1:0] rnd;
    logic             sticky, inc;
    int               d, lz, en, rs;

    assign ua = unpack(64'(operand_a_i), EA, MA);
    assign ub = unpack(64'(operand_b_i), EB, MB);

    // align, add, normalise, round
    always_comb begin
        big    = ub;
        sml    = ua;
        sticky = 1'b0;
        lz     = 0;
        rs     = 0;
        // order by magnitude so an effective subtraction never goes negative
        if ($signed(ua.ex) > $signed(ub.ex) || (ua.ex == ub.ex && ua.sig >= ub.sig)) begin
            big = ua;
            sml = ub;
        end
        big_x = {big.sig, 3'b000};
        sml_x = {sml.sig, 3'b000};
        d     = int'($signed(big.ex) - $signed(sml.ex));
        if (d >= W) begin
            sticky = |sml_x;
            sml_x  = '0;
        end else begin
            sticky = |(sml_x & ((W'(1) << d) - W'(1)));
            sml_x  = sml_x >> d;
        end
        sml_x[0] = sml_x[0] | sticky;
        raw = (big.sgn ^ sml.sgn) ? ({1'b0, big_x} - {1'b0, sml_x})
                                  : ({1'b0, big_x} + {1'b0, sml_x});
        en = int'($signed(big.ex));
        if (raw[W]) begin
            nrm = raw[W:1] | {{(W-1){1'b0}}, raw[0]};
            en  = en + 1;
        end else begin
            lz = W;
            for (int i = 0; i < W; i++)
                if (raw[i]) lz = W - 1 - i;
            nrm = raw[W-1:0] << lz;
            en  = en - lz;
        end
        // below the normal range: shift into subnormal position, exponent field 0
        if (en < 1) begin
            rs = 1 - en;
            if (rs >= W) begin
                sticky = |nrm;
                nrm    = '0;
            end else begin
                sticky = |(nrm & ((W'(1) << rs) - W'(1)));
                nrm    = nrm >> rs;
            end
            nrm[0] = nrm[0] | sticky;
            en     = 0;
        end
        // a mantissa carry ripples into the exponent, reaching inf if needed
        inc = nrm[2] & (nrm[1] | nrm[0] | nrm[3]);
        rnd = {en[EO-1:0], nrm[W-2:3]} + (EO+MO)'(inc);
    end

    // special-case selection
    always_comb begin
        result_o = {big.sgn, rnd};
        if (ua.nan || ub.nan || (ua.inf && ub.inf && (ua.sgn != ub.sgn)))
            result_o = {1'b0, {EO{1'b1}}, 1'b1, {(MO-1){1'b0}}};
        else if (ua.inf)
            result_o = {ua.sgn, {EO{1'b1}}, {MO{1'b0}}};
        else if (ub.inf)
            result_o = {ub.sgn, {EO{1'b1}}, {MO{1'b0}}};
        else if (raw == '0)
            result_o = '0;
        else if (en >= MaxExp)
            result_o = {big.sgn, {EO{1'b1}}, {MO{1'b0}}};
    end

endmodule

// File: rtl/fp_acc_reduce.sv
// Streaming FP reduction: sums a configured-length burst of input-format
// elements into an output-format accumulator and returns one result per burst.
// Optional macro FP_ACC_REDUCE_STATUS_EN adds status_o = {nan_seen, inf_seen}.
module fp_acc_reduce
    import fpnew_pkg_snax::*;
#(
    parameter fp_format_e  FpFormat_in  = fp_format_e'(2),
    parameter fp_format_e  FpFormat_out = fp_format_e'(0),
    parameter int unsigned LenWidth     = 16,
    localparam int unsigned WidthIn  = fp_width(FpFormat_in),
    localparam int unsigned WidthOut = fp_width(FpFormat_out)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [LenWidth-1:0] cfg_len_i,
    input  logic                cfg_valid_i,
    output logic                cfg_ready_o,
    input  logic [WidthIn-1:0]  in_data_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    output logic [WidthOut-1:0] out_data_o,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic                busy_o
`ifdef FP_ACC_REDUCE_STATUS_EN
    ,
    output logic [1:0]          status_o
`endif
);

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} acc_state_e;

    acc_state_e          state_q, state_d;
    logic [WidthOut-1:0] acc_q, acc_d, sum;
    logic [LenWidth-1:0] cnt_q, cnt_d, len_q, len_d;
    logic                cfg_hs, in_hs, out_hs, last;

    assign cfg_hs = cfg_valid_i & cfg_ready_o;
    assign in_hs  = in_valid_i & in_ready_o;
    assign out_hs = out_valid_o & out_ready_i;
    assign last   = (cnt_q == len_q - LenWidth'(1));

    fp_add #(
        .FpFormat_a   (FpFormat_in),
        .FpFormat_b   (FpFormat_out),
        .FpFormat_out (FpFormat_out)
    ) i_fp_add (
        .operand_a_i (in_data_i),
        .operand_b_i (acc_q),
        .result_o    (sum)
    );

    // state and datapath registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
        end
    end

    // next state: zero-length bursts skip straight to the result
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cfg_hs) state_d = (cfg_len_i == '0) ? DONE : ACCUM;
            ACCUM:   if (in_hs && last) state_d = DONE;
            DONE:    if (out_hs) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // handshake outputs are pure functions of the state
    always_comb begin
        cfg_ready_o = (state_q == IDLE);
        in_ready_o  = (state_q == ACCUM);
        out_valid_o = (state_q == DONE);
        busy_o      = (state_q == ACCUM) || (state_q == DONE);
    end

    assign out_data_o = acc_q;

    // accumulator/counter: clear on config, fold in each accepted element
    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        len_d = len_q;
        if (cfg_hs) begin
            acc_d = '0;
            if (cfg_len_i != '0) begin
                len_d = cfg_len_i;
                cnt_d = '0;
            end
        end
        if (in_hs) begin
            acc_d = sum;
            cnt_d = cnt_q + LenWidth'(1);
        end
    end

`ifdef FP_ACC_REDUCE_STATUS_EN
    localparam int ExpIn  = int'(exp_bits(FpFormat_in));
    localparam int ManIn  = int'(man_bits(FpFormat_in));
    localparam int ExpOut = int'(exp_bits(FpFormat_out));
    localparam int ManOut = int'(man_bits(FpFormat_out));

    logic nan_q, nan_d, inf_q, inf_d, in_nan, sum_inf;

    assign in_nan  = (&in_data_i[WidthIn-2 -: ExpIn]) && (|in_data_i[ManIn-1:0]);
    assign sum_inf = (&sum[WidthOut-2 -: ExpOut]) && (sum[ManOut-1:0] == '0);

    // sticky per-burst flags
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            nan_q <= 1'b0;
            inf_q <= 1'b0;
        end else begin
            nan_q <= nan_d;
            inf_q <= inf_d;
        end
    end

    // flags clear on config and set from accepted elements / add results
    always_comb begin
        nan_d = nan_q;
        inf_d = inf_q;
        if (cfg_hs) begin
            nan_d = 1'b0;
            inf_d = 1'b0;
        end
        if (in_hs) begin
            nan_d = nan_q | in_nan;
            inf_d = inf_q | sum_inf;
        end
    end

    assign status_o = {nan_q, inf_q};
`endif

endmodule

// File: tb/tb_fp_acc_reduce.sv
// Directed self-checking bench for fp_acc_reduce (FP16 in, FP32 out).
module tb_fp_acc_reduce;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] cfg_len, in_data;
    logic        cfg_valid, cfg_ready, in_valid, in_ready;
    logic        out_valid, out_ready, busy;
    logic [31:0] out_data;
`ifdef FP_ACC_REDUCE_STATUS_EN
    logic [1:0]  status;
`endif
    logic [15:0] bp_vec [5];
    int          n_chk = 0, n_pass = 0, n_fail = 0;

    fp_acc_reduce dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .cfg_len_i   (cfg_len),
        .cfg_valid_i (cfg_valid),
        .cfg_ready_o (cfg_ready),
        .in_data_i   (in_data),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .out_data_o  (out_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .busy_o      (busy)
`ifdef FP_ACC_REDUCE_STATUS_EN
        ,
        .status_o    (status)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_status(input logic [1:0] exp);
`ifdef FP_ACC_REDUCE_STATUS_EN
        chk("status", {30'd0, status}, {30'd0, exp});
`else
        if (exp == 2'b11) $display("status flags not built");
`endif
    endtask

    // advance to just after the next rising edge
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_cfg(input logic [15:0] len);
        int k = 0;
        while (!cfg_ready && k < 100) begin cycle(); k++; end
        chk("cfg_rdy", {31'd0, cfg_ready}, 32'd1);
        cfg_valid = 1'b1;
        cfg_len   = len;
        cycle();
        cfg_valid = 1'b0;
    endtask

    task automatic send(input logic [15:0] d);
        int k = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && k < 100) begin cycle(); k++; end
        chk("in_rdy", {31'd0, in_ready}, 32'd1);
        cycle();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        while (!out_valid && k < 100) begin cycle(); k++; end
        chk("out_vld", {31'd0, out_valid}, 32'd1);
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; cfg_len = '0; cfg_valid = 1'b0;
        in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
        bp_vec[0] = 16'h3C00; bp_vec[1] = 16'h4000; bp_vec[2] = 16'h3800;
        bp_vec[3] = 16'hC200; bp_vec[4] = 16'h4400;
        #12;
        chk("rst_data",  out_data, 32'h0);
        chk("rst_ovld",  {31'd0, out_valid}, 32'd0);
        chk("rst_irdy",  {31'd0, in_ready}, 32'd0);
        chk("rst_busy",  {31'd0, busy}, 32'd0);
        chk("rst_crdy",  {31'd0, cfg_ready}, 32'd1);
        check_status(2'b00);
        @(negedge clk) rst_n = 1'b1;
        cycle();

        // 4 x 1.0 back-to-back; result visible right after the 4th handshake
        do_cfg(16'd4);
        chk("sum_busy", {31'd0, busy}, 32'd1);
        repeat (4) send(16'h3C00);
        chk("sum_ovld", {31'd0, out_valid}, 32'd1);
        chk("sum_data", out_data, 32'h40800000);
        chk("sum_irdy", {31'd0, in_ready}, 32'd0);
        check_status(2'b00);
        // consume with cfg offered in the same cycle: must not be taken
        cfg_valid = 1'b1; cfg_len = 16'd3; out_ready = 1'b1;
        cycle();
        cfg_valid = 1'b0; out_ready = 1'b0;
        chk("drain_ovld", {31'd0, out_valid}, 32'd0);
        chk("drain_busy", {31'd0, busy}, 32'd0);
        chk("drain_crdy", {31'd0, cfg_ready}, 32'd1);

        // zero-length burst, with an element offered that must be ignored
        in_valid = 1'b1; in_data = 16'h3C00;
        do_cfg(16'd0);
        chk("zl_ovld", {31'd0, out_valid}, 32'd1);
        chk("zl_data", out_data, 32'h0);
        chk("zl_irdy", {31'd0, in_ready}, 32'd0);
        cycle();
        chk("zl_hold", out_data, 32'h0);
        in_valid = 1'b0;
        drain();

        // 2.0 + (-2.0) cancels to +0
        do_cfg(16'd2);
        send(16'h4000);
        chk("cxl_mid", out_data, 32'h40000000);
        send(16'hC000);
        chk("cxl_data", out_data, 32'h00000000);
        drain();

        // NaN in the middle poisons the rest of the burst
        do_cfg(16'd3);
        send(16'h3C00);
        send(16'h7E00);
        send(16'h3C00);
        chk("nan_data", out_data, 32'h7FC00000);
        check_status(2'b10);
        drain();

        // smallest FP16 subnormal widens to an FP32 normal
        do_cfg(16'd1);
        send(16'h0001);
        chk("sub_data", out_data, 32'h33800000);
        check_status(2'b00);
        drain();

        // gaps between elements, cfg offered mid-burst, then output backpressure
        do_cfg(16'd5);
        for (int i = 0; i < 5; i++) begin
            send(bp_vec[i]);
            if (i < 4) begin
                repeat ($urandom_range(0, 3)) begin
                    cfg_valid = 1'b1; cfg_len = 16'd9;
                    cycle();
                    chk("bp_gap_crdy", {31'd0, cfg_ready}, 32'd0);
                    chk("bp_gap_ovld", {31'd0, out_valid}, 32'd0);
                end
                cfg_valid = 1'b0;
            end
        end
        chk("bp_ovld", {31'd0, out_valid}, 32'd1);
        chk("bp_data", out_data, 32'h40900000);
        repeat (5) begin
            cycle();
            chk("bp_hold_ovld", {31'd0, out_valid}, 32'd1);
            chk("bp_hold_data", out_data, 32'h40900000);
            chk("bp_hold_crdy", {31'd0, cfg_ready}, 32'd0);
        end
        drain();
        chk("bp_after_crdy", {31'd0, cfg_ready}, 32'd1);

        // reset after 2 of 4 elements discards the burst
        do_cfg(16'd4);
        send(16'h3C00);
        send(16'h3C00);
        rst_n = 1'b0;
        #2;
        chk("mrst_busy", {31'd0, busy}, 32'd0);
        chk("mrst_crdy", {31'd0, cfg_ready}, 32'd1);
        chk("mrst_irdy", {31'd0, in_ready}, 32'd0);
        chk("mrst_data", out_data, 32'h0);
        @(negedge clk) rst_n = 1'b1;
        cycle();
        do_cfg(16'd1);
        send(16'h3C00);
        chk("post_rst_data", out_data, 32'h3F800000);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
